// File: rtl/traffic_pkg.sv
// Shared definitions for traffic-light phase timing: controller state
// encoding and the default timing constants.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam int DEF_WIDTH    = 7;
  localparam int DEF_IDLE_VAL = 99;        // legacy 99 s phase
  localparam int DEF_TICK_DIV = 50000000;  // 1 s at 50 MHz
  localparam int DEF_WARN     = 3;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick strobe every pTICK_DIV enabled cycles.
// A pending tick is held while disabled so a freeze never drops it.
module tick_prescaler #(
  parameter int pTICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (pTICK_DIV > 1) ? $clog2(pTICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(pTICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = tick_q;
    if (clr) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else if (en) begin
      tick_d = (cnt_q == CNT_LAST);
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/phase_countdown_timer.sv
// Loadable phase down-counter with prescaled tick, pause/abort, one-shot or
// auto-reload expiry, and warning/last decodes for the light controller.
module phase_countdown_timer
  import traffic_pkg::*;
#(
  parameter int pWIDTH    = DEF_WIDTH,
  parameter int pIDLE_VAL = DEF_IDLE_VAL,
  parameter int pTICK_DIV = DEF_TICK_DIV,
  parameter int pWARN     = DEF_WARN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [pWIDTH-1:0] load_val,
  input  logic              mode_reload,
  input  logic              pause,
  input  logic              abort,
  output logic [pWIDTH-1:0] count,
  output logic              tick,
  output logic              last,
  output logic              pre_last,
  output logic              warn,
  output logic              done,
  output logic              busy
);

  localparam logic [pWIDTH-1:0] IDLE_CNT = pWIDTH'(pIDLE_VAL);
  localparam logic [pWIDTH-1:0] CNT_ONE  = pWIDTH'(1);

  state_e            state_q, state_d;
  logic [pWIDTH-1:0] count_q, count_d;
  logic [pWIDTH-1:0] reload_q, reload_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;
  logic              pre_tick;
  logic              pre_en, pre_clr;

  // Prescaler only advances on cycles where RUN actually continues, so a
  // cycle taken by abort/start/pause never moves it.
  assign pre_en  = (state_q == ST_RUN) && !abort && !start && !pause;
  assign pre_clr = abort || start;

  tick_prescaler #(
    .pTICK_DIV(pTICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (pre_en),
    .clr (pre_clr),
    .tick(pre_tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      count_d = IDLE_CNT;
    end else if (start) begin
      count_d  = load_val;
      reload_d = load_val;
      mode_d   = mode_reload;
      state_d  = pause ? ST_PAUSE : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (pre_tick) begin
            if (count_q != '0) begin
              count_d = count_q - CNT_ONE;
            end else begin
              done_d = 1'b1;
              if (mode_q) count_d = reload_q;
              else        state_d = ST_EXPIRED;
            end
          end
        end
        ST_PAUSE: if (!pause) state_d = ST_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= IDLE_CNT;
      reload_q <= IDLE_CNT;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  assign count    = count_q;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign tick     = pre_tick && (state_q == ST_RUN);
  assign last     = (count_q == '0) && (state_q != ST_IDLE);
  assign pre_last = (count_q == CNT_ONE) && (state_q != ST_IDLE);
  assign warn     = busy && (count_q != '0) && (int'(count_q) <= pWARN);
  assign done     = done_q;

endmodule

// File: tb/tb_phase_countdown_timer.sv
// Scoreboard bench for phase_countdown_timer: dut_a divides by 4, dut_b ticks every cycle.
module tb_phase_countdown_timer;

  typedef struct packed {
    logic [6:0] count;
    logic       tick;
    logic       last;
    logic       pre_last;
    logic       warn;
    logic       done;
    logic       busy;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, mode_a = 1'b0, pause_a = 1'b0, abort_a = 1'b0;
  logic [6:0] load_a = '0;
  logic [6:0] count_a;
  logic       tick_a, last_a, pre_last_a, warn_a, done_a, busy_a;
  logic       start_b = 1'b0, mode_b = 1'b0, pause_b = 1'b0, abort_b = 1'b0;
  logic [6:0] load_b = '0;
  logic [6:0] count_b;
  logic       tick_b, last_b, pre_last_b, warn_b, done_b, busy_b;

  int   vectors = 0;
  int   miscompares = 0;
  out_t sb[$];
  out_t got, want;

  always #5 clk = ~clk;

  phase_countdown_timer #(.pWIDTH(7), .pIDLE_VAL(99), .pTICK_DIV(4), .pWARN(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .load_val(load_a), .mode_reload(mode_a),
    .pause(pause_a), .abort(abort_a), .count(count_a), .tick(tick_a), .last(last_a),
    .pre_last(pre_last_a), .warn(warn_a), .done(done_a), .busy(busy_a));

  phase_countdown_timer #(.pWIDTH(7), .pIDLE_VAL(99), .pTICK_DIV(1), .pWARN(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .load_val(load_b), .mode_reload(mode_b),
    .pause(pause_b), .abort(abort_b), .count(count_b), .tick(tick_b), .last(last_b),
    .pre_last(pre_last_b), .warn(warn_b), .done(done_b), .busy(busy_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic out_t obs(input bit sel_b);
    if (sel_b) return '{count_b, tick_b, last_b, pre_last_b, warn_b, done_b, busy_b};
    return '{count_a, tick_a, last_a, pre_last_a, warn_a, done_a, busy_a};
  endfunction

  // Expected outputs from the spec's decode definitions; active = state is not IDLE.
  function automatic out_t mk(input int cnt, input bit bsy, input bit active,
                              input bit tk, input bit dn);
    out_t o;
    o.count    = 7'(cnt);
    o.tick     = tk;
    o.last     = active && (cnt == 0);
    o.pre_last = active && (cnt == 1);
    o.warn     = bsy && (cnt >= 1) && (cnt <= 3);
    o.done     = dn;
    o.busy     = bsy;
    return o;
  endfunction

  task automatic test_reset();
    step();
    step();
    for (int c = 0; c < 2; c++) sb.push_back(mk(99, 0, 0, 0, 0));
    got = obs(0); want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_a got=%h want=%h", got, want); end
    got = obs(1); want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_b got=%h want=%h", got, want); end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) sb.push_back(mk(99, 0, 0, 0, 0));
    for (int c = 0; c < 4; c++) begin
      step();
      got = obs(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL idle c=%0d got=%h want=%h", c, got, want); end
    end
  endtask

  task automatic test_one_shot();
    start_a = 1; load_a = 7'd3; mode_a = 0;
    for (int c = 0; c < 20; c++)
      sb.push_back(mk(c < 5 ? 3 : c < 9 ? 2 : c < 13 ? 1 : 0, c < 17, 1,
                      (c >= 4 && c <= 16 && c % 4 == 0), c == 17));
    step();
    start_a = 0;
    for (int c = 0; c < 20; c++) begin
      got = obs(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL one_shot c=%0d got=%h want=%h", c, got, want); end
      step();
    end
  endtask

  task automatic test_auto_reload();
    int seq[3] = '{1, 0, 2};
    start_a = 1; load_a = 7'd2; mode_a = 1;
    for (int c = 0; c < 30; c++)
      sb.push_back(mk(c < 5 ? 2 : seq[((c - 5) / 4) % 3], 1, 1,
                      (c >= 4 && c % 4 == 0), (c >= 13 && (c - 13) % 12 == 0)));
    step();
    start_a = 0;
    for (int c = 0; c < 30; c++) begin
      got = obs(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL auto_reload c=%0d got=%h want=%h", c, got, want); end
      if (c < 29) step();
    end
    abort_a = 1;
    sb.push_back(mk(99, 0, 0, 0, 0));
    step();
    abort_a = 0;
    got = obs(0); want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reload_abort got=%h want=%h", got, want); end
  endtask

  task automatic test_pause();
    start_a = 1; load_a = 7'd5; mode_a = 0;
    for (int c = 0; c < 22; c++)
      sb.push_back(mk(c < 16 ? 5 : c < 20 ? 4 : 3, 1, 1, (c == 15 || c == 19), 0));
    step();
    start_a = 0;
    for (int c = 0; c < 22; c++) begin
      got = obs(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL pause c=%0d got=%h want=%h", c, got, want); end
      pause_a = (c >= 2 && c <= 11);
      step();
    end
    abort_a = 1;
    step();
    abort_a = 0; pause_a = 1;
    for (int c = 0; c < 3; c++) sb.push_back(mk(99, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++) begin
      step();
      got = obs(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL pause_idle c=%0d got=%h want=%h", c, got, want); end
    end
    pause_a = 0;
  endtask

  task automatic test_priority();
    start_a = 1; load_a = 7'd9; mode_a = 0;
    for (int c = 0; c < 13; c++)
      sb.push_back(mk(c < 5 ? 9 : c < 7 ? 8 : c < 12 ? 7 : 6, 1, 1, (c == 4 || c == 11), 0));
    step();
    start_a = 0;
    for (int c = 0; c < 13; c++) begin
      got = obs(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL restart c=%0d got=%h want=%h", c, got, want); end
      start_a = (c == 6);
      load_a  = 7'd7;
      step();
    end
    start_a = 1; abort_a = 1; load_a = 7'd5;
    sb.push_back(mk(99, 0, 0, 0, 0));
    step();
    start_a = 0; abort_a = 0;
    got = obs(0); want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL start_abort got=%h want=%h", got, want); end
  endtask

  task automatic test_reset_mid_run();
    start_a = 1; load_a = 7'd1; mode_a = 0;
    for (int c = 0; c < 13; c++)
      if (c < 9) sb.push_back(mk(c < 5 ? 1 : 0, 1, 1, (c == 4 || c == 8), 0));
      else       sb.push_back(mk(99, 0, 0, 0, 0));
    step();
    start_a = 0;
    for (int c = 0; c < 13; c++) begin
      got = obs(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL rst_mid_run c=%0d got=%h want=%h", c, got, want); end
      rst = (c == 8);
      step();
    end
    rst = 0;
  endtask

  task automatic test_load_zero();
    start_a = 1; load_a = 7'd0; mode_a = 0;
    for (int c = 0; c < 10; c++)
      sb.push_back(mk(0, c < 5, 1, c == 4, c == 5));
    step();
    start_a = 0;
    for (int c = 0; c < 10; c++) begin
      got = obs(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL load_zero c=%0d got=%h want=%h", c, got, want); end
      pause_a = (c >= 6);
      step();
    end
    start_a = 1; load_a = 7'd4; pause_a = 1;
    for (int c = 0; c < 6; c++) sb.push_back(mk(4, 1, 1, 0, 0));
    step();
    start_a = 0;
    for (int c = 0; c < 6; c++) begin
      got = obs(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL start_paused c=%0d got=%h want=%h", c, got, want); end
      step();
    end
    abort_a = 1;
    step();
    abort_a = 0; pause_a = 0;
  endtask

  task automatic test_fast_tick();
    start_b = 1; load_b = 7'd3; mode_b = 0;
    sb.push_back(mk(3, 1, 1, 0, 0));
    sb.push_back(mk(3, 1, 1, 1, 0));
    sb.push_back(mk(2, 1, 1, 1, 0));
    sb.push_back(mk(1, 1, 1, 1, 0));
    sb.push_back(mk(0, 1, 1, 1, 0));
    sb.push_back(mk(0, 0, 1, 0, 1));
    sb.push_back(mk(0, 0, 1, 0, 0));
    step();
    start_b = 0;
    for (int c = 0; c < 7; c++) begin
      got = obs(1); want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL fast_tick c=%0d got=%h want=%h", c, got, want); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    start_b = 1; load_b = 7'd0; mode_b = 1;
    for (int c = 0; c < 8; c++) sb.push_back(mk(0, 1, 1, c >= 1, c >= 2));
    step();
    start_b = 0;
    for (int c = 0; c < 8; c++) begin
      got = obs(1); want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL reload_zero c=%0d got=%h want=%h", c, got, want); end
      step();
    end
    abort_b = 1;
    sb.push_back(mk(99, 0, 0, 0, 0));
    step();
    abort_b = 0;
    got = obs(1); want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL fast_abort got=%h want=%h", got, want); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    abort_a = 1; step(); abort_a = 0;
    test_auto_reload();
    test_pause();
    test_priority();
    test_reset_mid_run();
    test_load_zero();
    test_fast_tick();
    test_back_to_back();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
